// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared types for the per-warp instruction buffer: decoded payload layout and default depth.
package vx_warp_ibuffer_pkg;

  localparam int NUM_WARPS_DEF = 4;
  localparam int NUM_THREADS   = 4;
  localparam int IBUF_SIZE     = 4;

  // Decoded instruction minus the warp id, which is consumed by steering.
  typedef struct packed {
    logic [15:0]            uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [1:0]             ex_type;
    logic [3:0]             op_type;
    logic [7:0]             op_args;
    logic                   wb;
    logic [5:0]             rd;
    logic [5:0]             rs1;
    logic [5:0]             rs2;
    logic [5:0]             rs3;
`ifdef EXT_V_ENABLE
    logic [2:0]             vsew;
    logic [2:0]             vlmul;
    logic                   vm;
`endif
  } ibuf_data_t;

  localparam int IBUF_DATA_W = $bits(ibuf_data_t);

endpackage

// File: rtl/vx_warp_ibuffer_queue.sv
// Single-warp FIFO of DEPTH entries; head is the registered oldest entry, no bypass paths.
module vx_ibuf_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) push |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) pop |-> !empty);
`endif

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: steers decoded instructions by wid into per-warp FIFOs,
// presents each warp's head on its own valid/ready channel and reports registered pops.
module vx_warp_ibuffer
  import vx_warp_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int DEPTH     = IBUF_SIZE,
  parameter int DATA_W    = IBUF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        decode_valid,
  input  logic [NW_WIDTH-1:0]         decode_wid,
  input  logic [DATA_W-1:0]           decode_data,
  output logic                        decode_ready,
  output logic [NUM_WARPS-1:0]        ibuf_valid,
  output logic [NUM_WARPS*DATA_W-1:0] ibuf_data,
  input  logic [NUM_WARPS-1:0]        ibuf_ready,
  output logic [NUM_WARPS-1:0]        ibuf_pop
);

  logic [NUM_WARPS-1:0]     full;
  logic [NUM_WARPS-1:0]     empty;
  logic [NUM_WARPS-1:0]     push;
  logic [NUM_WARPS-1:0]     deq;
  logic [2**NW_WIDTH-1:0]   full_pad;
  logic                     fire;

  // Unused wid codes read as full so an illegal wid is never accepted.
  always_comb begin
    full_pad                = '1;
    full_pad[NUM_WARPS-1:0] = full;
  end

  assign decode_ready = ~full_pad[decode_wid];
  assign fire         = decode_valid & decode_ready;
  assign ibuf_valid   = ~empty;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w] = fire & (decode_wid == NW_WIDTH'(w));
    assign deq[w]  = ~empty[w] & ibuf_ready[w];

    vx_ibuf_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push[w]),
      .push_data (decode_data),
      .pop       (deq[w]),
      .full      (full[w]),
      .empty     (empty[w]),
      .head      (ibuf_data[w*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) ibuf_pop <= '0;
    else       ibuf_pop <= deq;
  end

`ifndef SYNTHESIS
  a_wid_range: assert property (@(posedge clk) disable iff (reset)
                                decode_valid |-> (32'(decode_wid) < NUM_WARPS));
`endif

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Bench for vx_warp_ibuffer: directed scenarios then random traffic against a queue-based model.
module tb_vx_warp_ibuffer;
  import vx_warp_ibuffer_pkg::*;

  localparam int NW    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = IBUF_DATA_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            decode_valid;
  logic [1:0]      decode_wid;
  logic [DW-1:0]   decode_data;
  logic            decode_ready;
  logic [NW-1:0]   ibuf_valid;
  logic [NW*DW-1:0] ibuf_data;
  logic [NW-1:0]   ibuf_ready;
  logic [NW-1:0]   ibuf_pop;

  vx_warp_ibuffer #(
    .NUM_WARPS (NW),
    .NW_WIDTH  (2),
    .DEPTH     (DEPTH),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .decode_valid (decode_valid),
    .decode_wid   (decode_wid),
    .decode_data  (decode_data),
    .decode_ready (decode_ready),
    .ibuf_valid   (ibuf_valid),
    .ibuf_data    (ibuf_data),
    .ibuf_ready   (ibuf_ready),
    .ibuf_pop     (ibuf_pop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: one plain queue per warp plus the pop pattern expected next cycle.
  logic [DW-1:0] mq [NW][$];
  logic [NW-1:0] exp_pop;
  bit            armed;
  bit            last_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] pc);
    ibuf_data_t d;
    d         = '0;
    d.uuid    = 16'($urandom);
    d.tmask   = 4'($urandom);
    d.pc      = pc;
    d.op_type = 4'($urandom);
    d.op_args = 8'($urandom);
    d.rd      = 6'($urandom);
    d.rs1     = 6'($urandom);
    return d;
  endfunction

  task automatic drv(input bit v, input int wid, input logic [DW-1:0] d);
    decode_valid = v;
    decode_wid   = 2'(wid);
    decode_data  = d;
  endtask

  // One clock: compare outputs against the model before the edge, then advance the model.
  task automatic step();
    logic [NW-1:0] deq;
    logic [NW-1:0] exp_valid;
    bit            acc;
    @(negedge clk);
    for (int w = 0; w < NW; w++) begin
      exp_valid[w] = (mq[w].size() > 0);
      deq[w]       = ibuf_ready[w] && (mq[w].size() > 0);
    end
    acc = decode_valid && (mq[decode_wid].size() < DEPTH);
    if (armed) begin
      chk($sformatf("decode_ready_w%0d", decode_wid), 128'(decode_ready),
          128'(mq[decode_wid].size() < DEPTH));
      chk("ibuf_valid", 128'(ibuf_valid), 128'(exp_valid));
      chk("ibuf_pop", 128'(ibuf_pop), 128'(exp_pop));
      for (int w = 0; w < NW; w++)
        if (mq[w].size() > 0)
          chk($sformatf("head_w%0d", w), 128'(ibuf_data[w*DW +: DW]), 128'(mq[w][0]));
    end
    @(posedge clk);
    if (reset) begin
      for (int w = 0; w < NW; w++) mq[w].delete();
      exp_pop  = '0;
      armed    = 1'b1;
      last_acc = 1'b0;
    end else begin
      for (int w = 0; w < NW; w++)
        if (deq[w]) void'(mq[w].pop_front());
      if (acc) mq[decode_wid].push_back(decode_data);
      exp_pop  = deq;
      last_acc = acc;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; ibuf_ready = '0; armed = 1'b0; exp_pop = '0; last_acc = 1'b0;
    drv(0, 0, '0);
    step(); step();
    reset = 1'b0;

    // Single push to warp 2, then consume it and watch the delayed pop pulse.
    drv(1, 2, mk(32'h8000_0000)); step();
    drv(0, 0, '0); ibuf_ready = 4'b0100; step();
    ibuf_ready = '0; step(); step();

    // Fill warp 1, probe wid 0, then push into the full warp.
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, mk(32'h100 + 32'(4*i))); step();
    end
    drv(0, 0, '0); step();
    drv(1, 1, mk(32'h110)); step();
    ibuf_ready = 4'b0010; step();
    ibuf_ready = '0; step();
    drv(0, 0, '0); ibuf_ready = 4'b0010;
    repeat (5) step();
    ibuf_ready = '0;

    // Warp 0 held at two entries with push and pop every cycle.
    drv(1, 0, mk(32'h200)); step();
    drv(1, 0, mk(32'h204)); step();
    ibuf_ready = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, mk(32'h208 + 32'(4*i))); step();
    end
    drv(0, 0, '0);
    repeat (4) step();
    ibuf_ready = '0; step();

    // One entry per warp, all drained together.
    for (int w = 0; w < NW; w++) begin
      drv(1, w, mk(32'h300 + 32'(w))); step();
    end
    drv(0, 0, '0); ibuf_ready = 4'b1111; step();
    ibuf_ready = '0; step(); step();

    // Reset with warp 3 partly full discards entries without pops.
    for (int i = 0; i < 3; i++) begin
      drv(1, 3, mk(32'h400 + 32'(4*i))); step();
    end
    drv(0, 0, '0); reset = 1'b1; step();
    reset = 1'b0; ibuf_ready = 4'b1111;
    for (int w = 0; w < NW; w++) begin
      decode_wid = 2'(w); step();
    end
    ibuf_ready = '0;

    // Random traffic; a stalled request is held until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(decode_valid && !last_acc))
        drv(($urandom_range(0, 3) != 0), int'($urandom_range(0, NW-1)), mk($urandom));
      ibuf_ready = 4'($urandom);
      step();
    end
    drv(0, 0, '0); ibuf_ready = 4'b1111;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
